// File: rtl/string_1101_finder_pkg.sv
// Shared state definitions for the 1101 serial pattern detector.
package string_1101_finder_pkg;

  localparam int STATE_W = 2;

  // Each state names the longest prefix of 1101 already seen.
  typedef enum logic [STATE_W-1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

endpackage

// File: rtl/string_1101_finder_if.sv
// Serial data input, match strobe, state visibility and match counter bundle.
interface string_1101_finder_if #(
  parameter int COUNT_W = 8
);

  logic               in_valid;
  logic               in;
  logic               out;
  logic               c1;
  logic               c0;
  logic               next1;
  logic               next0;
  logic [COUNT_W-1:0] match_count;

  modport master (
    output in_valid, in,
    input  out, c1, c0, next1, next0, match_count
  );

  modport slave (
    input  in_valid, in,
    output out, c1, c0, next1, next0, match_count
  );

endinterface

// File: rtl/string_1101_finder_next_state.sv
// Combinational transition table and Mealy match output for the 1101 detector.
module string1101_next_state
  import string_1101_finder_pkg::*;
(
  input  logic c0,
  input  logic c1,
  input  logic in,
  output logic next0,
  output logic next1,
  output logic out
);

  state_e cur_s;
  state_e nxt_s;
  logic   hit_s;

  assign cur_s = state_e'({c1, c0});

  // Transition table; a match reuses its trailing 1 as the next S1.
  always_comb begin
    nxt_s = S0;
    hit_s = 1'b0;
    case (cur_s)
      S0: begin
        if (in) nxt_s = S1;
        else    nxt_s = S0;
      end
      S1: begin
        if (in) nxt_s = S2;
        else    nxt_s = S0;
      end
      S2: begin
        if (in) nxt_s = S2;
        else    nxt_s = S3;
      end
      S3: begin
        if (in) begin
          nxt_s = S1;
          hit_s = 1'b1;
        end else begin
          nxt_s = S0;
          hit_s = 1'b0;
        end
      end
      default: begin
        nxt_s = S0;
        hit_s = 1'b0;
      end
    endcase
  end

  assign next1 = nxt_s[1];
  assign next0 = nxt_s[0];
  assign out   = hit_s;

endmodule

// File: rtl/string_1101_finder.sv
// 1101 serial pattern detector: state register, in_valid hold and saturating match counter.
module string_1101_finder
  import string_1101_finder_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  string_1101_finder_if.slave  bus
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  state_e             next_s;
  logic               tbl_n1_s;
  logic               tbl_n0_s;
  logic               tbl_hit_s;
  logic               out_s;
  logic [COUNT_W-1:0] count_r;

  string1101_next_state u_next_state (
    .c0    (state_r[0]),
    .c1    (state_r[1]),
    .in    (bus.in),
    .next0 (tbl_n0_s),
    .next1 (tbl_n1_s),
    .out   (tbl_hit_s)
  );

  // Invalid cycles freeze the state and suppress the strobe.
  always_comb begin
    next_s = state_r;
    out_s  = 1'b0;
    if (bus.in_valid) begin
      next_s = state_e'({tbl_n1_s, tbl_n0_s});
      out_s  = tbl_hit_s;
    end else begin
      next_s = state_r;
      out_s  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S0;
    end else begin
      state_r <= next_s;
    end
  end

  // Match counter, holding once it reaches all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (out_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.out         = out_s;
  assign bus.c1          = state_r[1];
  assign bus.c0          = state_r[0];
  assign bus.next1       = next_s[1];
  assign bus.next0       = next_s[0];
  assign bus.match_count = count_r;

endmodule

// File: tb/tb_string_1101_finder.sv
// Self-checking bench for string_1101_finder against a sliding-window reference model.
module tb_string_1101_finder;
  import string_1101_finder_pkg::*;

  logic clk = 1'b0;
  logic rst;

  string_1101_finder_if #(.COUNT_W(8)) bus8 ();
  string_1101_finder_if #(.COUNT_W(2)) bus2 ();

  string_1101_finder #(.COUNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  string_1101_finder #(.COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic tt_c1, tt_c0, tt_in, tt_n1, tt_n0, tt_out;
  string1101_next_state u_tt (
    .c0(tt_c0), .c1(tt_c1), .in(tt_in),
    .next0(tt_n0), .next1(tt_n1), .out(tt_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: last four valid bits and the total number of matches.
  logic [3:0] w_m;
  int         cnt_m;
  logic       v_d, b_d;

  // Longest suffix of the window that is a proper prefix of 1101.
  function automatic logic [1:0] suffix_state(input logic [3:0] w);
    if (w[2:0] == 3'b110) return 2'b11;
    if (w[1:0] == 2'b11)  return 2'b10;
    if (w[0])             return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_out(input logic v, input logic b);
    return v && b && (w_m[2:0] == 3'b110);
  endfunction

  function automatic logic [1:0] exp_next(input logic v, input logic b);
    if (v) return suffix_state({w_m[2:0], b});
    return suffix_state(w_m);
  endfunction

  function automatic logic [7:0] exp_cnt8();
    return (cnt_m > 255) ? 8'd255 : 8'(cnt_m);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (cnt_m > 3) ? 2'd3 : 2'(cnt_m);
  endfunction

  task automatic model_clear();
    w_m   = 4'b0000;
    cnt_m = 0;
  endtask

  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    v_d = v;
    b_d = b;
    bus8.in_valid = v;
    bus8.in       = b;
    bus2.in_valid = v;
    bus2.in       = b;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (v_d) begin
      if (b_d && (w_m[2:0] == 3'b110)) cnt_m++;
      w_m = {w_m[2:0], b_d};
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_d = 1'b0;
    b_d = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in       = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in       = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] pre;
    do_reset();
    checks++;
    if ({bus8.c1, bus8.c0} !== 2'b00) $display("FAIL reset_state: got %b want 00", {bus8.c1, bus8.c0});
    else passed++;
    checks++;
    if (bus8.match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus8.match_count);
    else passed++;
    pre = 6'b110110;
    for (int i = 5; i >= 0; i--) begin
      drive(1'b1, pre[i]);
      advance();
    end
    drive(1'b1, 1'b1);
    checks++;
    if (bus8.out !== 1'b1) $display("FAIL reset_prematch_out: got %b want 1", bus8.out);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus8.c1, bus8.c0, bus8.match_count} !== 10'd0)
      $display("FAIL async_reset_state_count: got %b/%0d want 00/0", {bus8.c1, bus8.c0}, bus8.match_count);
    else passed++;
    checks++;
    if (bus8.out !== 1'b0) $display("FAIL async_reset_out: got %b want 0", bus8.out);
    else passed++;
    do_reset();
  endtask

  task automatic test_truth_table();
    logic [2:0] exp_tbl [8];
    logic [2:0] idx;
    // {next1,next0,out} indexed by {c1,c0,in}
    exp_tbl[0] = 3'b000; exp_tbl[1] = 3'b010;
    exp_tbl[2] = 3'b000; exp_tbl[3] = 3'b100;
    exp_tbl[4] = 3'b110; exp_tbl[5] = 3'b100;
    exp_tbl[6] = 3'b000; exp_tbl[7] = 3'b011;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {tt_c1, tt_c0, tt_in} = idx;
      #1;
      checks++;
      if ({tt_n1, tt_n0, tt_out} !== exp_tbl[i])
        $display("FAIL truth_table c1c0in=%b: got %b want %b", idx, {tt_n1, tt_n0, tt_out}, exp_tbl[i]);
      else passed++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] outs;
    do_reset();
    bits = 7'b1101101;
    outs = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      checks++;
      if (bus8.out !== outs[i]) $display("FAIL overlap_out bit%0d: got %b want %b", 7 - i, bus8.out, outs[i]);
      else passed++;
      advance();
    end
    checks++;
    if (bus8.match_count !== 8'd2) $display("FAIL overlap_count: got %0d want 2", bus8.match_count);
    else passed++;
    checks++;
    if ({bus8.c1, bus8.c0} !== 2'b01) $display("FAIL overlap_final_state: got %b want 01", {bus8.c1, bus8.c0});
    else passed++;
  endtask

  task automatic test_non_match();
    logic [7:0] bits;
    int         seen;
    do_reset();
    bits = 8'b10100111;
    seen = 0;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      if (bus8.out !== 1'b0) seen++;
      advance();
    end
    checks++;
    if (seen != 0) $display("FAIL non_match_out: got %0d strobes want 0", seen);
    else passed++;
    checks++;
    if ({bus8.c1, bus8.c0} !== 2'b10) $display("FAIL non_match_final_state: got %b want 10", {bus8.c1, bus8.c0});
    else passed++;
  endtask

  task automatic test_valid_gating();
    logic [2:0] bits;
    do_reset();
    bits = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1);
      checks++;
      if ({bus8.out, bus8.next1, bus8.next0} !== 3'b011)
        $display("FAIL gating_out_next cyc%0d: got %b want 011", k, {bus8.out, bus8.next1, bus8.next0});
      else passed++;
      advance();
      checks++;
      if ({bus8.c1, bus8.c0, bus8.match_count} !== {2'b11, 8'd0})
        $display("FAIL gating_hold cyc%0d: got %b/%0d want 11/0", k, {bus8.c1, bus8.c0}, bus8.match_count);
      else passed++;
    end
    drive(1'b1, 1'b1);
    checks++;
    if (bus8.out !== 1'b1) $display("FAIL gating_release_out: got %b want 1", bus8.out);
    else passed++;
    advance();
    checks++;
    if (bus8.match_count !== 8'd1) $display("FAIL gating_release_count: got %0d want 1", bus8.match_count);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [12:0] bits;
    do_reset();
    bits = 13'b1101101101101;
    for (int i = 12; i >= 0; i--) begin
      drive(1'b1, bits[i]);
      if (i == 0) begin
        checks++;
        if (bus2.out !== 1'b1) $display("FAIL sat_fourth_out: got %b want 1", bus2.out);
        else passed++;
      end
      advance();
      if (i == 3 || i == 0) begin
        checks++;
        if (bus2.match_count !== 2'd3) $display("FAIL sat_count2 after bit%0d: got %0d want 3", 13 - i, bus2.match_count);
        else passed++;
      end
    end
    checks++;
    if (bus8.match_count !== 8'd4) $display("FAIL sat_count8: got %0d want 4", bus8.match_count);
    else passed++;
  endtask

  task automatic test_random();
    logic v, b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 4) != 0);
      b = 1'($urandom_range(0, 1));
      drive(v, b);
      checks++;
      if ({bus8.out, bus8.next1, bus8.next0} !== {exp_out(v, b), exp_next(v, b)})
        $display("FAIL rand_comb cyc%0d: got %b want %b", i, {bus8.out, bus8.next1, bus8.next0}, {exp_out(v, b), exp_next(v, b)});
      else passed++;
      checks++;
      if (bus2.out !== exp_out(v, b)) $display("FAIL rand_out2 cyc%0d: got %b want %b", i, bus2.out, exp_out(v, b));
      else passed++;
      advance();
      checks++;
      if ({bus8.c1, bus8.c0} !== suffix_state(w_m))
        $display("FAIL rand_state cyc%0d: got %b want %b", i, {bus8.c1, bus8.c0}, suffix_state(w_m));
      else passed++;
      checks++;
      if (bus8.match_count !== exp_cnt8()) $display("FAIL rand_count8 cyc%0d: got %0d want %0d", i, bus8.match_count, exp_cnt8());
      else passed++;
      checks++;
      if (bus2.match_count !== exp_cnt2()) $display("FAIL rand_count2 cyc%0d: got %0d want %0d", i, bus2.match_count, exp_cnt2());
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    test_reset();
    test_truth_table();
    test_overlap();
    test_non_match();
    test_valid_gating();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
